seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus and one hex-to-7-segment decoder. It holds a frame of hex nibbles, selects one digit per time slot, and inserts a dark guard interval at the start of each slot to prevent ghosting. New display data is committed only at frame boundaries, so a frame never shows a mix of old and new values. The block sits between the game logic, which supplies the values, and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8).
SCAN_DIV, 50000, clocks per digit slot (≥2).
BLANK_CYCLES, 500, dark clocks at the start of each slot (0 ≤ BLANK_CYCLES < SCAN_DIV).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load  in  1  1-cycle request to stage data_in
data_in  in  4*NUM_DIGITS  nibble k = bits [4k+3:4k]; digit 0 is the least significant
blank_mask  in  NUM_DIGITS  1 = force that digit dark; sampled live
lz_en  in  1  leading-zero blanking enable; sampled live
seg  out  7  active-low segments {g,f,e,d,c,b,a}; 7'h7F = dark
an  out  NUM_DIGITS  active-low digit enables; at most one bit low
load_ack  out  1  1-cycle pulse when staged data is committed
frame_done  out  1  1-cycle pulse at the end of every frame

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-low; it is sampled on the clk rising edge only.
- Reset values: cnt=0, idx=0, state=BLANK, active=0, shadow=0, pending=0, seg=7'h7F, an=all 1s, load_ack=0, frame_done=0.
- Reset mid-frame: the next edge with rst_n=0 applies the reset values above. Pending data is discarded and no ack is issued.
- Counter: cnt runs 0..SCAN_DIV-1. At the wrap, cnt returns to 0 and idx advances (wrapping NUM_DIGITS-1 → 0).
- States:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE for the remainder of the slot.
  - DRIVE → BLANK at every slot wrap.
  - With BLANK_CYCLES=0 the state is always DRIVE.
- Outputs are registered with 1-cycle latency: an and seg reflect cnt/idx/state of the previous cycle.
  - In BLANK: an = all 1s, seg = 7'h7F.
  - In DRIVE with digit idx visible: an[idx]=0 and seg = decode(active nibble idx).
  - In DRIVE with digit idx hidden: an = all 1s and seg = 7'h7F.
- Visibility: digit k is hidden if blank_mask[k]=1, or if all of the following hold:
  - lz_en=1,
  - k≠0,
  - nibble k and every nibble above it are 0.
  Digit 0 is never hidden by lz_en.
- Staging:
  - load=1 writes data_in to shadow and sets pending.
  - A further load while pending overwrites shadow (last write wins); only one ack is issued.
- Commit edge: the edge where cnt=SCAN_DIV-1 and idx=NUM_DIGITS-1.
  - frame_done pulses on this edge.
  - If pending: active ← shadow, pending ← 0, load_ack pulses on this edge.
  - If load=1 on this same edge: active ← data_in directly, load_ack pulses, pending ← 0.
  - Data committed on this edge is displayed starting with digit 0 of the next frame.
- Width rules: cnt is $clog2(SCAN_DIV) bits and idx is $clog2(NUM_DIGITS) bits (minimum 1). Comparisons use full-width constants and no value overflows its register.

Decomposition:
- Shared package (seg_pkg):
  - constant SEG_BLANK=7'h7F,
  - state encoding BLANK=1'b0, DRIVE=1'b1,
  - the function computing an all-ones anode vector.
- Sub-module: instantiate the team's existing hex-to-seven-segment decoder exactly once on the selected nibble. Sharing a single decoder is the purpose of this block.
- The leading-zero mask is a small combinational function in this module; no new sub-module.

Test Plan:
- Reset/scan timing (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2), release rst_n with active=0 → an=4'b1111 for 2 cycles after the 1st edge, then 4'b1110 with seg=7'h40 for 6 cycles, then 2 dark cycles, then 4'b1101. frame_done pulses every 32 cycles.
- load data_in=16'h12AF mid-frame → display is unchanged until the commit edge. load_ack and frame_done pulse together on that edge. The next frame shows digit0 seg=7'h0E (F), digit1 7'h08 (A), digit2 7'h24 (2), digit3 7'h79 (1).
- lz_en=1 with active=16'h0005 → only digit0 drives (seg=7'h12). Slots 1–3 keep an=4'b1111. With active=16'h0000, digit0 shows 7'h40.
- blank_mask=4'b0100 with active=16'h1234 → slot 2 stays dark; the other digits are unaffected.
- Back-to-back loads 16'h1111 then 16'h2222 before the boundary → a single load_ack, and 16'h2222 is displayed. A load asserted exactly on the commit edge commits data_in in that same cycle.
- rst_n=0 for one cycle in slot 2 with pending=1 → the next outputs are dark, idx=0, no load_ack, and active=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   SEG_BLANK    : active-low segment pattern with every segment off
//   scan_state_e : per-slot phase, dark guard interval then drive
//   an_all_off() : all-ones (all digits disabled) anode vector for n digits
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        StBlank = 1'b0,
        StDrive = 1'b1
    } scan_state_e;

    // Anodes are active-low, so "all off" is a run of n ones.
    function automatic logic [7:0] an_all_off(input int unsigned n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Hex nibble to common-anode 7-segment decoder.
//   nibble_i : value 0..F
//   seg_o    : active-low segments {g,f,e,d,c,b,a}
module seg_scan_ctrl_hex7seg (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = 7'h40;
            4'h1:    seg_o = 7'h79;
            4'h2:    seg_o = 7'h24;
            4'h3:    seg_o = 7'h30;
            4'h4:    seg_o = 7'h19;
            4'h5:    seg_o = 7'h12;
            4'h6:    seg_o = 7'h02;
            4'h7:    seg_o = 7'h78;
            4'h8:    seg_o = 7'h00;
            4'h9:    seg_o = 7'h10;
            4'hA:    seg_o = 7'h08;
            4'hB:    seg_o = 7'h03;
            4'hC:    seg_o = 7'h46;
            4'hD:    seg_o = 7'h21;
            4'hE:    seg_o = 7'h06;
            default: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one
// segment bus and one decoder. Each slot starts with a dark guard interval; new data is only
// committed at frame boundaries so a frame never mixes old and new values.
//   clk_i          : system clock
//   rst_n_i        : synchronous active-low reset
//   load_i         : one-cycle request to stage data_in_i
//   data_in_i      : nibble k at [4k+3:4k], digit 0 least significant
//   blank_mask_i   : 1 forces the digit dark (live)
//   lz_en_i        : leading-zero blanking enable (live)
//   seg_o          : active-low segments {g,f,e,d,c,b,a}
//   an_o           : active-low digit enables, at most one low
//   load_ack_o     : pulse when staged data is committed
//   frame_done_o   : pulse at the end of every frame
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] data_in_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
    input  logic                    lz_en_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    load_ack_o,
    output logic                    frame_done_o
);

    localparam int unsigned CntW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW = 4 * NUM_DIGITS;

    localparam logic [CntW-1:0]       CntMax   = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]       CntBlank = CntW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0]       IdxMax   = IdxW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AnOff    = NUM_DIGITS'(an_all_off(NUM_DIGITS));

    // Digit k (k > 0) is a leading zero when it and every nibble above it are zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DataW-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (d[4*k +: 4] == 4'h0);
            m[k]       = zero_above;
        end
        return m;
    endfunction

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    scan_state_e           state_q, state_d;
    logic [DataW-1:0]      active_q, active_d;
    logic [DataW-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] hidden;
    logic [3:0]            sel_nib;
    logic                  sel_vis;
    logic [NUM_DIGITS-1:0] sel_an;
    logic [6:0]            dec_seg;

    // Single decoder shared by all digits; fed with the nibble of the current slot.
    seg_scan_ctrl_hex7seg u_dec (
        .nibble_i (sel_nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        hidden  = blank_mask_i | (lz_en_i ? lz_mask(active_q) : '0);
        sel_nib = 4'h0;
        sel_vis = 1'b0;
        sel_an  = AnOff;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IdxW'(k)) begin
                sel_nib   = active_q[4*k +: 4];
                sel_vis   = ~hidden[k];
                sel_an[k] = 1'b0;
            end
        end
    end

    always_comb begin
        slot_end  = (cnt_q == CntMax);
        frame_end = slot_end && (idx_q == IdxMax);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
        state_d = (cnt_d < CntBlank) ? StBlank : StDrive;

        // Outputs are registered from this cycle's cnt/idx/state.
        an_d  = AnOff;
        seg_d = SEG_BLANK;
        if (state_q == StDrive && sel_vis) begin
            an_d  = sel_an;
            seg_d = dec_seg;
        end

        frame_done_d = frame_end;

        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (load_i) begin
            if (frame_end) begin
                // Load on the commit edge bypasses the shadow.
                active_d   = data_in_i;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end else begin
                shadow_d  = data_in_i;
                pending_d = 1'b1;
            end
        end else if (frame_end && pending_q) begin
            active_d   = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= StBlank;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AnOff;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign an_o         = an_q;
    assign load_ack_o   = load_ack_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// A frame is 32 cycles. With n counted in falling edges after the edge that raised
// frame_done, digit k of the new frame is driven for n = 3+8k .. 8+8k.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        load_ack;
    logic        frame_done;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .load_i       (load),
        .data_in_i    (data_in),
        .blank_mask_i (blank_mask),
        .lz_en_i      (lz_en),
        .seg_o        (seg),
        .an_o         (an),
        .load_ack_o   (load_ack),
        .frame_done_o (frame_done)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
        logic        lz;
        int          digit;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Returns at the falling edge where frame_done is high (n = 0).
    task automatic wait_fd();
        int i;
        i = 0;
        while (frame_done !== 1'b1 && i < 80) begin
            @(negedge clk);
            i++;
        end
        if (frame_done !== 1'b1) check("wait_frame_done timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        blank_mask = v.mask;
        lz_en      = v.lz;
        data_in    = v.data;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd();
        check($sformatf("vec%0d load_ack", idx), load_ack, 1);
        repeat (5 + 8 * v.digit) @(negedge clk);
        check($sformatf("vec%0d an", idx), an, v.exp_an);
        check($sformatf("vec%0d seg", idx), seg, v.exp_seg);
    endtask

    vec_t vecs[$];

    initial begin
        int  acks;
        logic early;

        vecs = '{
            '{16'h12AF, 4'b0000, 1'b0, 0, 4'b1110, 7'h0E},
            '{16'h12AF, 4'b0000, 1'b0, 1, 4'b1101, 7'h08},
            '{16'h12AF, 4'b0000, 1'b0, 2, 4'b1011, 7'h24},
            '{16'h12AF, 4'b0000, 1'b0, 3, 4'b0111, 7'h79},
            '{16'h0005, 4'b0000, 1'b1, 0, 4'b1110, 7'h12},
            '{16'h0005, 4'b0000, 1'b1, 1, 4'b1111, 7'h7F},
            '{16'h0005, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F},
            '{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'h40},
            '{16'h0000, 4'b0000, 1'b1, 2, 4'b1111, 7'h7F},
            '{16'h1234, 4'b0100, 1'b0, 0, 4'b1110, 7'h19},
            '{16'h1234, 4'b0100, 1'b0, 1, 4'b1101, 7'h30},
            '{16'h1234, 4'b0100, 1'b0, 2, 4'b1111, 7'h7F},
            '{16'h1234, 4'b0100, 1'b0, 3, 4'b0111, 7'h79},
            '{16'h0100, 4'b0000, 1'b1, 1, 4'b1101, 7'h40},
            '{16'h0100, 4'b0000, 1'b1, 2, 4'b1011, 7'h79},
            '{16'h0100, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F},
            '{16'h0000, 4'b0000, 1'b0, 3, 4'b0111, 7'h40}
        };

        rst_n      = 1'b0;
        load       = 1'b0;
        data_in    = 16'h0;
        blank_mask = 4'b0000;
        lz_en      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset an", an, 4'b1111);
        check("reset seg", seg, 7'h7F);
        check("reset load_ack", load_ack, 0);
        check("reset frame_done", frame_done, 0);

        // Scan timing from reset release; c counts edges after release.
        rst_n = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                check($sformatf("boot c%0d an", c), an, 4'b1111);
            end else if (c <= 8) begin
                check($sformatf("boot c%0d an", c), an, 4'b1110);
                check($sformatf("boot c%0d seg", c), seg, 7'h40);
            end else if (c <= 10) begin
                check($sformatf("boot c%0d an", c), an, 4'b1111);
                check($sformatf("boot c%0d seg", c), seg, 7'h7F);
            end else if (c == 11) begin
                check("boot c11 an", an, 4'b1101);
            end
            if (c == 31 || c == 32 || c == 33 || c == 64)
                check($sformatf("boot c%0d frame_done", c), frame_done, (c == 32 || c == 64));
        end

        // Mid-frame load must not show until the commit edge.
        early = 1'b0;
        for (int n = 1; n <= 31; n++) begin
            @(negedge clk);
            if (!(seg == 7'h7F || seg == 7'h40) || load_ack) early = 1'b1;
            load    = (n == 10);
            data_in = 16'h12AF;
        end
        load = 1'b0;
        @(negedge clk);
        check("no early display/ack", early, 0);
        check("commit frame_done", frame_done, 1);
        check("commit load_ack", load_ack, 1);
        repeat (5) @(negedge clk);
        check("after commit d0 seg", seg, 7'h0E);

        // Back-to-back loads, then a load exactly on the commit edge.
        @(negedge clk);
        wait_fd();
        acks = 0;
        for (int n = 1; n <= 96; n++) begin
            @(negedge clk);
            if (n <= 62 && load_ack) acks++;
            if (n == 37) begin
                check("b2b d0 an", an, 4'b1110);
                check("b2b d0 seg", seg, 7'h24);
            end
            if (n == 64) begin
                check("edge load ack", load_ack, 1);
                check("edge load frame_done", frame_done, 1);
            end
            if (n == 69) check("edge load d0 seg", seg, 7'h30);
            if (n == 96) check("no stale ack", load_ack, 0);
            load    = (n == 3 || n == 4 || n == 63);
            data_in = (n == 3) ? 16'h1111 : (n == 4) ? 16'h2222 : 16'h3333;
        end
        load = 1'b0;
        check("b2b single ack", acks, 1);

        // One-cycle reset in slot 2 with data pending.
        wait_fd();
        acks = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (load_ack) acks++;
            if (n == 19) begin
                check("midreset an", an, 4'b1111);
                check("midreset seg", seg, 7'h7F);
                check("midreset frame_done", frame_done, 0);
            end
            if (n == 22) begin
                check("postreset an", an, 4'b1110);
                check("postreset seg", seg, 7'h40);
            end
            if (n == 51) check("postreset frame_done", frame_done, 1);
            if (n == 57) check("postreset pending dropped", seg, 7'h40);
            load    = (n == 17);
            data_in = 16'h5555;
            rst_n   = !(n == 18);
        end
        rst_n = 1'b1;
        check("midreset no ack", acks, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
